// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE accepts a request, RESP returns its response)
//   PORT0/PORT1 : port identifiers used for owner and last_grant
//   gnt_port    : converts a one-hot 2-bit grant into a port identifier
package dmem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    function automatic logic gnt_port(input logic [1:0] gnt);
        return gnt[1] ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter.
//   valid/we/addr/wdata : request, held stable by the requester until ready
//   ready               : request accepted this cycle
//   rsp_valid/rsp_rdata : one-cycle response pulse; rdata is 0 for write acks
// Modports: master = requester side, slave = arbiter side.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
) ();
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-input grant logic, purely combinational.
//   req[1:0]   : request vector (bit N = port N valid)
//   last_grant : port granted most recently
//   gnt[1:0]   : one-hot grant, all zero when nothing is requested
// FIXED_PRIO=0 alternates on a tie (grants the port not granted last);
// FIXED_PRIO=1 always favours port 0 on a tie.
module rr_arb2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = '0;
        if (&req) begin
            if (FIXED_PRIO || last_grant) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else begin
            gnt = req;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port registered-read data memory between two requesters
// (port 0: CPU load/store unit, port 1: debug/program loader).
//   clk, reset     : clock (rising edge) and synchronous active-high reset
//   p0, p1         : requester ports (valid/ready request, one-cycle response)
//   mem_address    : memory word address
//   mem_write_data : memory write data
//   mem_we         : memory write enable
//   mem_read_data  : memory read data, valid the cycle after the address
// One transaction is outstanding at a time: accept in IDLE, respond in RESP.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DATA_W     = 32,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     p0,
    dmem_arbiter_if.slave     p1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_read_data
);
    arb_state_t state, state_d;
    logic       owner, owner_d;
    logic       we_q, we_d;
    logic       last_grant, last_grant_d;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       sel;

    assign req = {p1.valid, p0.valid};

    rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .req       (req),
        .last_grant(last_grant),
        .gnt       (gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= PORT0;
            we_q       <= 1'b0;
            last_grant <= PORT1;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            we_q       <= we_d;
            last_grant <= last_grant_d;
        end
    end

    // Outputs are gated by reset so a response pending in RESP is dropped
    // in the same cycle reset is asserted, not one cycle later.
    always_comb begin
        state_d        = state;
        owner_d        = owner;
        we_d           = we_q;
        last_grant_d   = last_grant;
        sel            = gnt_port(gnt);
        p0.ready       = 1'b0;
        p1.ready       = 1'b0;
        p0.rsp_valid   = 1'b0;
        p1.rsp_valid   = 1'b0;
        p0.rsp_rdata   = '0;
        p1.rsp_rdata   = '0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_we         = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        state_d      = RESP;
                        owner_d      = sel;
                        last_grant_d = sel;
                        if (sel == PORT1) begin
                            p1.ready       = 1'b1;
                            mem_address    = p1.addr;
                            mem_write_data = p1.wdata;
                            mem_we         = p1.we;
                            we_d           = p1.we;
                        end else begin
                            p0.ready       = 1'b1;
                            mem_address    = p0.addr;
                            mem_write_data = p0.wdata;
                            mem_we         = p0.we;
                            we_d           = p0.we;
                        end
                    end
                end
                RESP: begin
                    state_d = IDLE;
                    if (owner == PORT1) begin
                        p1.rsp_valid = 1'b1;
                        p1.rsp_rdata = we_q ? '0 : mem_read_data;
                    end else begin
                        p0.rsp_valid = 1'b1;
                        p0.rsp_rdata = we_q ? '0 : mem_read_data;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule
